iterative_multiplier_32: RTL and testbench



---
 rtl/iterative_multiplier_32_pkg.sv | 13 +
 rtl/iterative_multiplier_32_adder.sv | 24 ++
 rtl/iterative_multiplier_32.sv | 88 ++++++++
 tb/tb_iterative_multiplier_32.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/iterative_multiplier_32_pkg.sv
// Shared constants and FSM state encoding for the iterative 32x32 multiplier.
package iterative_multiplier_32_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = 6;
  localparam int LAST_ITER  = 31;

  // Encoding 2'd3 is unused; the FSM treats it exactly like IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/iterative_multiplier_32_adder.sv
// 32-bit ripple-carry adder built from per-bit full-adder equations.
module iterative_multiplier_32_adder
  import iterative_multiplier_32_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] a,
  input  logic [MULT_WIDTH-1:0] b,
  output logic [MULT_WIDTH-1:0] sum,
  output logic                  carryout
);

  logic w_carry;

  // Carry ripples LSB to MSB through one full adder per bit.
  always_comb begin
    sum     = '0;
    w_carry = 1'b0;
    for (int i = 0; i < MULT_WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    carryout = w_carry;
  end

endmodule

// File: rtl/iterative_multiplier_32.sv
// Sequential unsigned 32x32->64 shift-add multiplier, one ripple-adder pass per cycle,
// valid/ready handshakes on input and output.
module iterative_multiplier_32
  import iterative_multiplier_32_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nonzero
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH:0]   r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_gated;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_accept;
  logic               w_last;

  assign w_gated = r_m & {WIDTH{r_p[0]}};
  assign w_last  = (r_cnt == CNT_W'(ITERS - 1));

  iterative_multiplier_32_adder u_adder (
    .a        (r_p[2*WIDTH-1:WIDTH]),
    .b        (w_gated),
    .sum      (w_sum),
    .carryout (w_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    product      = '0;
    hi_nonzero   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        product    = r_p[2*WIDTH-1:0];
        hi_nonzero = |r_p[2*WIDTH:WIDTH];
        if (out_ready) w_next_state = IDLE;
      end
      default: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
    endcase
    w_accept = in_valid & in_ready;
  end

  // The add result and its carry become the new high word after the right shift,
  // so the carry out of bit 31 lands in P[63] and nothing is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_m   <= a;
      r_p   <= {{(WIDTH+1){1'b0}}, b};
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_p   <= {1'b0, w_cout, w_sum, r_p[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iterative_multiplier_32.sv
// Scoreboard bench for iterative_multiplier_32: expected products queued at acceptance.
module tb_iterative_multiplier_32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        hi_nonzero;

  typedef struct {
    logic [63:0] prod;
    logic        hi;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  iterative_multiplier_32 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .hi_nonzero (hi_nonzero)
  );

  always #5 clk = ~clk;

  // Drives one transaction through the accepting edge and queues its expected result.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.prod   = {32'b0, av} * {32'b0, bv};
    e.hi     = (e.prod[63:32] != 32'b0);
    sb.push_back(e);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #2;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (product !== 64'h0) begin n_fail++; $display("FAIL reset_product: got %h want 0", product); end
    n_tests++; if (hi_nonzero !== 1'b0) begin n_fail++; $display("FAIL reset_hi_nonzero: got %0b want 0", hi_nonzero); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_products;
    logic [31:0] ta[5] = '{32'h0, 32'h3, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic [31:0] tb[5] = '{32'h0, 32'h5, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL prod%0d_ready: got %0b want 1", i, in_ready); end
      send(ta[i], tb[i]);
      n_tests++; if (product !== 64'h0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL prod%0d_run_idle: product %h out_valid %0b want 0/0", i, product, out_valid);
      end
      wait_out(cyc);
      n_tests++; if (cyc !== 32) begin n_fail++; $display("FAIL prod%0d_latency: got %0d want 32", i, cyc); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++; if (product !== e.prod) begin n_fail++; $display("FAIL prod%0d_value: got %h want %h", i, product, e.prod); end
        n_tests++; if (hi_nonzero !== e.hi) begin n_fail++; $display("FAIL prod%0d_hi: got %0b want %0b", i, hi_nonzero, e.hi); end
      end
      @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL prod%0d_pulse: out_valid %0b in_ready %0b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    int   cyc;
    exp_t e;
    out_ready = 1'b0;
    send(32'hDEADBEEF, 32'h01234567);
    wait_out(cyc);
    n_tests++; if (cyc !== 32) begin n_fail++; $display("FAIL bp_latency: got %0d want 32", cyc); end
    e.prod = '0;
    e.hi   = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if (product !== e.prod || hi_nonzero !== e.hi) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h/%0b want %h/%0b", k, product, hi_nonzero, e.prod, e.hi);
      end
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_flags%0d: out_valid %0b in_ready %0b want 1/0", k, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid %0b in_ready %0b want 0/1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_no_ghost: out_valid %0b in_ready %0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h00000003);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'h0 || hi_nonzero !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: in_ready %0b out_valid %0b product %h hi %0b want 1/0/0/0",
                         in_ready, out_valid, product, hi_nonzero);
    end
    sb.delete();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %0b want 1", in_ready); end
    send(32'd7, 32'd6);
    wait_out(cyc);
    n_tests++; if (cyc !== 32) begin n_fail++; $display("FAIL midrst_latency: got %0d want 32", cyc); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++; if (product !== e.prod || product !== 64'd42) begin
        n_fail++; $display("FAIL midrst_value: got %h want %h", product, e.prod);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send($urandom, $urandom);
      wait_out(cyc);
      n_tests++; if (cyc !== 32) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want 32", i, cyc); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++; if (product !== e.prod || hi_nonzero !== e.hi) begin
          n_fail++; $display("FAIL b2b%0d_value: got %h/%0b want %h/%0b", i, product, hi_nonzero, e.prod, e.hi);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
